// File: rtl/kt_comm_pkg.sv
// Shared types and constants for the Knight's Tour host/robot serial link.
package kt_comm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam int          BAUD_DIV      = 2604;
    localparam logic [7:0]  ACK_BYTE_DFLT = 8'hA5;

endpackage

// File: rtl/UART_rx.sv
// 8N1 UART receiver; rdy holds until clr_rdy, sampling at mid-bit.
module UART_rx
    import kt_comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    logic        rx_meta_q, rx_sync_q;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic        act_q, act_d;
    logic        rdy_q, rdy_d;

    always_comb begin
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        act_d   = act_q;
        rdy_d   = rdy_q;
        if (clr_rdy) rdy_d = 1'b0;
        if (!act_q) begin
            if (!rx_sync_q) begin
                // first sample lands mid bit 0, one and a half bits after the start edge
                act_d  = 1'b1;
                baud_d = 16'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - 1);
                bit_d  = 4'd0;
            end
        end else if (baud_q != 16'd0) begin
            baud_d = baud_q - 16'd1;
        end else if (bit_q == 4'd8) begin
            act_d = 1'b0;
            rdy_d = 1'b1;
        end else begin
            shift_d = {rx_sync_q, shift_q[7:1]};
            bit_d   = bit_q + 4'd1;
            baud_d  = 16'(CLKS_PER_BIT - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            shift_q   <= '0;
            baud_q    <= '0;
            bit_q     <= '0;
            act_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            act_q     <= act_d;
            rdy_q     <= rdy_d;
        end
    end

    assign rx_data = shift_q;
    assign rdy     = rdy_q;

endmodule

// File: rtl/UART_tx.sv
// 8N1 UART transmitter; tx_done is a one-cycle pulse at the end of the stop bit.
module UART_tx
    import kt_comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    logic [8:0]  shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic        act_q, act_d;
    logic        done_q, done_d;

    always_comb begin
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        act_d   = act_q;
        done_d  = 1'b0;
        if (!act_q) begin
            if (trmt) begin
                shift_d = {tx_data, 1'b0};
                baud_d  = 16'(CLKS_PER_BIT - 1);
                bit_d   = 4'd0;
                act_d   = 1'b1;
            end
        end else if (baud_q != 16'd0) begin
            baud_d = baud_q - 16'd1;
        end else if (bit_q == 4'd9) begin
            act_d  = 1'b0;
            done_d = 1'b1;
        end else begin
            // ones shifted in form the stop bit and leave the line idling high
            shift_d = {1'b1, shift_q[8:1]};
            bit_d   = bit_q + 4'd1;
            baud_d  = 16'(CLKS_PER_BIT - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            act_q   <= act_d;
            done_q  <= done_d;
        end
    end

    assign TX      = shift_q[0];
    assign tx_done = done_q;

endmodule

// File: rtl/remote_comm.sv
// Host-side command sender: sends a 16-bit command as two UART bytes (high first)
// and waits for a one-byte response from the robot, flagging a timeout if none.
//
//  state | meaning
//  IDLE  | waiting for snd_cmd; stray RX bytes are discarded
//  HIGH  | high byte on the wire
//  LOW   | low byte on the wire
//  WAIT  | command sent, waiting for response byte or timeout
module remote_comm
    import kt_comm_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CLKS = 24'd5_000_000,
    parameter logic [7:0]  ACK_BYTE     = ACK_BYTE_DFLT,
    parameter int          CLKS_PER_BIT = BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    input  logic        RX,
    output logic        busy,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    output logic        ack,
    output logic        resp_timeout,
    input  logic        clr_resp_rdy
);

    state_t      state_q, state_d;
    logic [7:0]  low_byte_q, low_byte_d;
    logic [7:0]  resp_q, resp_d;
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic        cmd_sent_q, cmd_sent_d;
    logic        resp_rdy_q, resp_rdy_d;
    logic        resp_timeout_q, resp_timeout_d;

    logic        trmt, tx_done, sel_low;
    logic [7:0]  tx_data, rx_data;
    logic        rx_rdy, clr_rdy;

    UART_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

    UART_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rx_rdy)
    );

    assign tx_data = sel_low ? low_byte_q : cmd[15:8];

    always_comb begin
        state_d        = state_q;
        low_byte_d     = low_byte_q;
        resp_d         = resp_q;
        tmo_cnt_d      = tmo_cnt_q;
        cmd_sent_d     = cmd_sent_q;
        resp_rdy_d     = resp_rdy_q;
        resp_timeout_d = resp_timeout_q;
        trmt           = 1'b0;
        sel_low        = 1'b0;
        clr_rdy        = 1'b0;
        if (clr_resp_rdy) resp_rdy_d = 1'b0;
        case (state_q)
            IDLE: begin
                clr_rdy = rx_rdy;
                if (snd_cmd) begin
                    low_byte_d     = cmd[7:0];
                    trmt           = 1'b1;
                    cmd_sent_d     = 1'b0;
                    resp_rdy_d     = 1'b0;
                    resp_timeout_d = 1'b0;
                    state_d        = HIGH;
                end
            end
            HIGH: begin
                clr_rdy = rx_rdy;
                if (tx_done) begin
                    trmt    = 1'b1;
                    sel_low = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                clr_rdy = rx_rdy;
                if (tx_done) begin
                    cmd_sent_d = 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // a byte arriving on the expiry cycle still counts as a response
                if (rx_rdy) begin
                    resp_d     = rx_data;
                    resp_rdy_d = 1'b1;
                    clr_rdy    = 1'b1;
                    state_d    = IDLE;
                end else if (tmo_cnt_q == TIMEOUT_CLKS - 24'd1) begin
                    resp_timeout_d = 1'b1;
                    state_d        = IDLE;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 24'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            low_byte_q     <= '0;
            resp_q         <= '0;
            tmo_cnt_q      <= '0;
            cmd_sent_q     <= 1'b0;
            resp_rdy_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            low_byte_q     <= low_byte_d;
            resp_q         <= resp_d;
            tmo_cnt_q      <= tmo_cnt_d;
            cmd_sent_q     <= cmd_sent_d;
            resp_rdy_q     <= resp_rdy_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign cmd_sent     = cmd_sent_q;
    assign resp_rdy     = resp_rdy_q;
    assign resp         = resp_q;
    assign resp_timeout = resp_timeout_q;
    assign ack          = resp_rdy_q && (resp_q == ACK_BYTE);

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: TX looped into a byte monitor, RX driven by a robot model.
module tb_remote_comm;

    localparam int          BAUD = 16;
    localparam logic [23:0] TMO  = 24'd1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snd_cmd = 1'b0;
    logic        RX = 1'b1;
    logic        clr_resp_rdy = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        TX, busy, cmd_sent, resp_rdy, ack, resp_timeout;
    logic [7:0]  resp;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  rx_q[$];

    remote_comm #(
        .TIMEOUT_CLKS (TMO),
        .ACK_BYTE     (8'hA5),
        .CLKS_PER_BIT (BAUD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd          (cmd),
        .snd_cmd      (snd_cmd),
        .TX           (TX),
        .RX           (RX),
        .busy         (busy),
        .cmd_sent     (cmd_sent),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .ack          (ack),
        .resp_timeout (resp_timeout),
        .clr_resp_rdy (clr_resp_rdy)
    );

    always #5 clk = ~clk;

    // serial monitor on TX; frames disturbed by reset are dropped
    initial begin
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge TX);
            ok = rst_n;
            b  = 8'h00;
            for (int i = 0; i < 8; i++) begin
                repeat (i == 0 ? BAUD + BAUD / 2 : BAUD) begin
                    @(negedge clk);
                    if (!rst_n) ok = 1'b0;
                end
                b[i] = TX;
            end
            if (ok) rx_q.push_back(b);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [15:0] c, input int hold);
        @(negedge clk);
        cmd     = c;
        snd_cmd = 1'b1;
        repeat (hold) @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    task automatic robot_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    function automatic logic sig_sel(input int which);
        case (which)
            0:       return cmd_sent;
            1:       return resp_rdy;
            2:       return resp_timeout;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, output int cycles, output logic hit);
        hit    = 1'b0;
        cycles = 0;
        while (!hit && cycles < budget) begin
            @(negedge clk);
            cycles++;
            hit = sig_sel(which);
        end
    endtask

    function automatic logic [15:0] two_bytes();
        if (rx_q.size() == 2) return {rx_q[0], rx_q[1]};
        return 16'hDEAD;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({TX, busy, cmd_sent, resp_rdy, resp_timeout, ack, resp} !== {6'b100000, 8'h00})
            $display("FAIL reset_state: got %b expected %b",
                     {TX, busy, cmd_sent, resp_rdy, resp_timeout, ack, resp}, {6'b100000, 8'h00});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_byte_order();
        int cyc; logic hit;
        rx_q.delete();
        send_cmd(16'h2A5C, 1);
        n_total++;
        if (busy !== 1'b1) $display("FAIL t1_busy_after_accept: got %b expected 1", busy);
        else n_pass++;
        for (int i = 0; i < 400 && rx_q.size() < 1; i++) @(negedge clk);
        n_total++;
        if ({rx_q.size() == 1, cmd_sent} !== 2'b10)
            $display("FAIL t1_first_byte_no_cmd_sent: got size1=%b cmd_sent=%b expected 1,0", rx_q.size() == 1, cmd_sent);
        else n_pass++;
        wait_for(0, 400, cyc, hit);
        n_total++;
        if (hit !== 1'b1) $display("FAIL t1_cmd_sent_wait: got no cmd_sent in 400 cycles expected 1");
        else n_pass++;
        n_total++;
        if (two_bytes() !== 16'h2A5C) $display("FAIL t1_bytes: got %h expected 2a5c", two_bytes());
        else n_pass++;
        repeat (500) @(negedge clk);
        n_total++;
        if ({busy, resp_timeout} !== 2'b10) $display("FAIL t1_busy_in_wait: got %b expected 10", {busy, resp_timeout});
        else n_pass++;
        robot_byte(8'h33);
        wait_for(1, 300, cyc, hit);
        n_total++;
        if (hit !== 1'b1) $display("FAIL t1_resp_wait: got no resp_rdy in 300 cycles expected 1");
        else n_pass++;
        n_total++;
        if ({resp, ack, busy} !== {8'h33, 2'b00}) $display("FAIL t1_resp: got %h expected %h", {resp, ack, busy}, {8'h33, 2'b00});
        else n_pass++;
    endtask

    task automatic test_ack();
        int cyc; logic hit;
        rx_q.delete();
        send_cmd(16'h4001, 1);
        wait_for(0, 400, cyc, hit);
        n_total++;
        if (hit !== 1'b1 || two_bytes() !== 16'h4001)
            $display("FAIL t2_bytes: got hit=%b bytes=%h expected 1 4001", hit, two_bytes());
        else n_pass++;
        robot_byte(8'hA5);
        wait_for(1, 300, cyc, hit);
        n_total++;
        if (hit !== 1'b1) $display("FAIL t2_resp_wait: got no resp_rdy in 300 cycles expected 1");
        else n_pass++;
        n_total++;
        if ({resp, resp_rdy, ack, busy} !== {8'hA5, 3'b110})
            $display("FAIL t2_ack: got %h expected %h", {resp, resp_rdy, ack, busy}, {8'hA5, 3'b110});
        else n_pass++;
        @(negedge clk) clr_resp_rdy = 1'b1;
        @(negedge clk) clr_resp_rdy = 1'b0;
        n_total++;
        if ({resp, resp_rdy, ack} !== {8'hA5, 2'b00})
            $display("FAIL t2_clr_resp_rdy: got %h expected %h", {resp, resp_rdy, ack}, {8'hA5, 2'b00});
        else n_pass++;
    endtask

    task automatic test_nak_and_discard();
        int cyc; logic hit;
        rx_q.delete();
        send_cmd(16'h1234, 1);
        wait_for(0, 400, cyc, hit);
        n_total++;
        if (hit !== 1'b1 || two_bytes() !== 16'h1234)
            $display("FAIL t3_bytes: got hit=%b bytes=%h expected 1 1234", hit, two_bytes());
        else n_pass++;
        robot_byte(8'h5A);
        wait_for(1, 300, cyc, hit);
        n_total++;
        if ({hit, resp, resp_rdy, ack} !== {1'b1, 8'h5A, 2'b10})
            $display("FAIL t3_nak: got %h expected %h", {hit, resp, resp_rdy, ack}, {1'b1, 8'h5A, 2'b10});
        else n_pass++;
        robot_byte(8'h77);
        repeat (40) @(negedge clk);
        n_total++;
        if ({resp, resp_rdy, busy} !== {8'h5A, 2'b10})
            $display("FAIL t3_idle_discard: got %h expected %h", {resp, resp_rdy, busy}, {8'h5A, 2'b10});
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cyc; logic hit;
        send_cmd(16'h0F0F, 1);
        n_total++;
        if ({resp_rdy, busy} !== 2'b01) $display("FAIL t4_accept_clears: got %b expected 01", {resp_rdy, busy});
        else n_pass++;
        wait_for(0, 400, cyc, hit);
        n_total++;
        if (hit !== 1'b1) $display("FAIL t4_cmd_sent_wait: got no cmd_sent in 400 cycles expected 1");
        else n_pass++;
        wait_for(2, 1100, cyc, hit);
        n_total++;
        if (hit !== 1'b1 || cyc != 1000)
            $display("FAIL t4_timeout_latency: got hit=%b cycles=%0d expected 1 1000", hit, cyc);
        else n_pass++;
        n_total++;
        if ({busy, cmd_sent, resp_rdy, resp_timeout} !== 4'b0101)
            $display("FAIL t4_after_timeout: got %b expected 0101", {busy, cmd_sent, resp_rdy, resp_timeout});
        else n_pass++;
    endtask

    task automatic test_held_and_busy_snd();
        int cyc; logic hit;
        rx_q.delete();
        @(negedge clk);
        cmd     = 16'h0000;
        snd_cmd = 1'b1;
        @(negedge clk);
        n_total++;
        if ({resp_timeout, cmd_sent, busy} !== 3'b001)
            $display("FAIL t5_new_send_clears: got %b expected 001", {resp_timeout, cmd_sent, busy});
        else n_pass++;
        repeat (4) @(negedge clk);
        snd_cmd = 1'b0;
        repeat (60) @(negedge clk);
        send_cmd(16'hFFFF, 1);
        repeat (150) @(negedge clk);
        send_cmd(16'hFFFF, 1);
        wait_for(0, 400, cyc, hit);
        n_total++;
        if (hit !== 1'b1) $display("FAIL t5_cmd_sent_wait: got no cmd_sent in 400 cycles expected 1");
        else n_pass++;
        wait_for(3, 1200, cyc, hit);
        n_total++;
        if (hit !== 1'b1) $display("FAIL t5_idle_wait: got busy stuck for 1200 cycles expected idle");
        else n_pass++;
        repeat (250) @(negedge clk);
        n_total++;
        if (rx_q.size() != 2) $display("FAIL t5_byte_count: got %0d expected 2", rx_q.size());
        else n_pass++;
        n_total++;
        if (two_bytes() !== 16'h0000) $display("FAIL t5_bytes: got %h expected 0000", two_bytes());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int cyc; logic hit;
        rx_q.delete();
        send_cmd(16'hC3C3, 1);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({TX, busy, cmd_sent, resp_rdy, resp_timeout, ack, resp} !== {6'b100000, 8'h00})
            $display("FAIL t6_in_reset: got %b expected %b",
                     {TX, busy, cmd_sent, resp_rdy, resp_timeout, ack, resp}, {6'b100000, 8'h00});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        n_total++;
        if ({rx_q.size() == 0, TX, busy} !== 3'b110)
            $display("FAIL t6_no_retransmit: got empty=%b TX=%b busy=%b expected 1,1,0", rx_q.size() == 0, TX, busy);
        else n_pass++;
        send_cmd(16'hB712, 1);
        wait_for(0, 400, cyc, hit);
        n_total++;
        if (hit !== 1'b1 || two_bytes() !== 16'hB712)
            $display("FAIL t6_bytes: got hit=%b bytes=%h expected 1 b712", hit, two_bytes());
        else n_pass++;
        robot_byte(8'hA5);
        wait_for(1, 300, cyc, hit);
        n_total++;
        if ({hit, resp, ack, busy} !== {1'b1, 8'hA5, 2'b10})
            $display("FAIL t6_resp: got %h expected %h", {hit, resp, ack, busy}, {1'b1, 8'hA5, 2'b10});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_byte_order();
        test_ack();
        test_nak_and_discard();
        test_timeout();
        test_held_and_busy_snd();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
